// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared FSM encoding, default widths and long-command constants.
// Revision : 1.0
// ============================================================================
package alu_arb_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_CW = 4;

  localparam logic [3:0] CMD_MUL_INC = 4'h9;
  localparam logic [3:0] CMD_SHL_SUB = 4'hA;

  localparam logic [1:0] SHORT_LAT = 2'd1;
  localparam logic [1:0] LONG_LAT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Brief    : Two-way one-hot arbiter; round-robin, or fixed priority to
//            requester 0 when ALU_ARB_FIXED_PRI_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_rr_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRI_EN
  logic w_unused;
  assign w_unused = CLK ^ RST ^ hs;

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // Index of the requester that won the most recent handshake.
  logic r_last;

  always_ff @(posedge CLK) begin
    if (RST)     r_last <= 1'b1;
    else if (hs) r_last <= gnt[1];
  end

  always_comb begin
    gnt = req;
    if (&req) gnt = r_last ? 2'b01 : 2'b10;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Serialises two requesters onto one shared ALU (issue/wait/capture).
//            Build option ALU_ARB_FIXED_PRI_EN selects fixed-priority arbitration.
// Revision : 1.0
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int NREQ = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][DW-1:0] req_opa,
  input  logic [NREQ-1:0][DW-1:0] req_opb,
  input  logic [NREQ-1:0][CW-1:0] req_cmd,
  input  logic [NREQ-1:0]         req_mode,
  input  logic [NREQ-1:0]         req_cin,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [DW+1:0]           rsp_res,
  output logic                    rsp_cout,
  output logic                    rsp_oflow,
  output logic                    rsp_g,
  output logic                    rsp_e,
  output logic                    rsp_l,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    ALU_CE,
  output logic                    ALU_MODE,
  output logic                    ALU_CIN,
  output logic [1:0]              ALU_INP_VALID,
  output logic [DW-1:0]           ALU_OPA,
  output logic [DW-1:0]           ALU_OPB,
  output logic [CW-1:0]           ALU_CMD,
  input  logic [DW+1:0]           ALU_RES,
  input  logic                    ALU_COUT,
  input  logic                    ALU_OFLOW,
  input  logic                    ALU_G,
  input  logic                    ALU_E,
  input  logic                    ALU_L,
  input  logic                    ALU_ERR
);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_cnt;
  logic [DW-1:0]   r_opa;
  logic [DW-1:0]   r_opb;
  logic [CW-1:0]   r_cmd;
  logic            r_mode;
  logic            r_cin;
  logic            r_id;
  logic [NREQ-1:0] w_gnt;
  logic            w_hs;
  logic            w_win;
  logic            w_long;

  alu_rr_arbiter u_arb (
    .CLK (CLK),
    .RST (RST),
    .req (req_valid),
    .hs  (w_hs),
    .gnt (w_gnt)
  );

  assign w_hs   = |(req_valid & req_ready);
  assign w_win  = w_gnt[1];
  assign w_long = r_mode && ((r_cmd == CW'(CMD_MUL_INC)) || (r_cmd == CW'(CMD_SHL_SUB)));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Operation fields are captured only at the handshake edge, so later
  // requester-side changes never reach the ALU.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= 2'd0;
      r_opa  <= '0;
      r_opb  <= '0;
      r_cmd  <= '0;
      r_mode <= 1'b0;
      r_cin  <= 1'b0;
      r_id   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_opa  <= req_opa[w_win];
        r_opb  <= req_opb[w_win];
        r_cmd  <= req_cmd[w_win];
        r_mode <= req_mode[w_win];
        r_cin  <= req_cin[w_win];
        r_id   <= w_win;
      end
      if (r_state == S_ISSUE)                       r_cnt <= w_long ? LONG_LAT : SHORT_LAT;
      else if (r_state == S_WAIT && r_cnt != 2'd0)  r_cnt <= r_cnt - 2'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_hs) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (r_cnt <= 2'd1) w_next = S_CAPTURE;
      S_CAPTURE: w_next = w_hs ? S_ISSUE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Every strobe is forced low while RST is high, whatever the state flop holds.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = 1'b0;
    rsp_id        = 1'b0;
    rsp_res       = '0;
    rsp_cout      = 1'b0;
    rsp_oflow     = 1'b0;
    rsp_g         = 1'b0;
    rsp_e         = 1'b0;
    rsp_l         = 1'b0;
    rsp_err       = 1'b0;
    busy          = 1'b0;
    ALU_INP_VALID = 2'b00;
    if (!RST) begin
      busy = (r_state != S_IDLE);
      if (r_state == S_IDLE || r_state == S_CAPTURE) req_ready = w_gnt;
      if (r_state == S_ISSUE) ALU_INP_VALID = 2'b11;
      if (r_state == S_CAPTURE) begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_res   = ALU_RES;
        rsp_cout  = ALU_COUT;
        rsp_oflow = ALU_OFLOW;
        rsp_g     = ALU_G;
        rsp_e     = ALU_E;
        rsp_l     = ALU_L;
        rsp_err   = ALU_ERR;
      end
    end
  end

  assign ALU_CE   = 1'b1;
  assign ALU_OPA  = r_opa;
  assign ALU_OPB  = r_opb;
  assign ALU_CMD  = r_cmd;
  assign ALU_MODE = r_mode;
  assign ALU_CIN  = r_cin;

endmodule
`default_nettype wire
